// File: rtl/sipo.sv
// Serial-in parallel-out deserializer: assembles WIDTH-bit words from an
// enabled serial stream, MSB- or LSB-first, and presents each finished word
// on a registered valid/ready output with one word of holding storage and a
// sticky overrun flag for words that arrive while the output is still full.
module sipo #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             sipo_in,
   input  logic             sipo_en,
   input  logic             LSB,
   input  logic             sync,
   input  logic             out_ready,
   input  logic             overrun_clr,
   output logic [WIDTH-1:0] sipo_out,
   output logic             out_valid,
   output logic             overrun
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr;
   logic [CW-1:0]    cnt;
   logic             ord;

   logic [WIDTH-1:0] shift_base;
   logic [WIDTH-1:0] sr_next;
   logic             first_bit;
   logic             ord_next;
   logic             word_done;
   logic             out_free;

   // Work out the shifted value, effective bit order and completion for this
   // cycle; a sync bit starts from an empty register so no partial survives.
   always_comb begin
      shift_base = sr;
      first_bit  = 1'b0;
      ord_next   = ord;
      sr_next    = sr;
      word_done  = 1'b0;
      out_free   = !out_valid || out_ready;
      if (sync) begin
         shift_base = '0;
      end
      first_bit = sync || (cnt == '0);
      if (first_bit) begin
         ord_next = LSB;
      end
      if (ord_next) begin
         sr_next = {sipo_in, shift_base[WIDTH-1:1]};
      end else begin
         sr_next = {shift_base[WIDTH-2:0], sipo_in};
      end
      word_done = sipo_en && !sync && (cnt == LAST);
   end

   // Shift register, bit counter and latched order; idle cycles hold them,
   // and a bare sync rewinds the counter so the next enabled bit is bit 0.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sr  <= '0;
         cnt <= '0;
         ord <= 1'b0;
      end else if (sipo_en) begin
         sr  <= sr_next;
         ord <= ord_next;
         if (sync) begin
            cnt <= CW'(1);
         end else if (cnt == LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end else if (sync) begin
         cnt <= '0;
      end
   end

   // Output holding register: load a finished word when the slot is free
   // (including the same-edge handoff), otherwise drop it and flag overrun;
   // set beats clear when both happen together.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sipo_out  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (word_done && out_free) begin
            sipo_out  <= sr_next;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (word_done && !out_free) begin
            overrun <= 1'b1;
         end else if (overrun_clr) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo.sv
// Directed testbench for sipo: hand-computed words covering both bit orders,
// gaps, backpressure/overrun, back-to-back handoff, sync and async reset.
module tb_sipo;

   logic       clk;
   logic       resetn;
   logic       sipo_in;
   logic       sipo_en;
   logic       LSB;
   logic       sync;
   logic       out_ready;
   logic       overrun_clr;
   logic [7:0] sipo_out;
   logic       out_valid;
   logic       overrun;

   int checks;
   int errors;
   int pulses;

   sipo #(.WIDTH(8)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .sipo_in     (sipo_in),
      .sipo_en     (sipo_en),
      .LSB         (LSB),
      .sync        (sync),
      .out_ready   (out_ready),
      .overrun_clr (overrun_clr),
      .sipo_out    (sipo_out),
      .out_valid   (out_valid),
      .overrun     (overrun)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expected value and tally it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, clock it in, and return 1 ns after the edge.
   task automatic applyStimulus(input logic b, input logic en, input logic sy);
      sipo_in = b;
      sipo_en = en;
      sync    = sy;
      @(posedge clk);
      #1;
      sipo_en = 1'b0;
      sync    = 1'b0;
      sipo_in = 1'b0;
   endtask

   // Send a full byte in the chosen order, back to back.
   task automatic sendWord(input logic [7:0] w, input logic lsbFirst);
      LSB = lsbFirst;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(lsbFirst ? w[i] : w[7-i], 1'b1, 1'b0);
      end
   endtask

   // Directed test sequence.
   initial begin
      logic [7:0] bits;
      logic [7:0] word;
      checks      = 0;
      errors      = 0;
      pulses      = 0;
      resetn      = 1'b0;
      sipo_in     = 1'b0;
      sipo_en     = 1'b0;
      LSB         = 1'b0;
      sync        = 1'b0;
      out_ready   = 1'b1;
      overrun_clr = 1'b0;
      #12;
      checkOutput("reset_out", {24'd0, sipo_out}, 32'h00);
      checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Test 1: MSB-first 0xC0 with out_ready high.
      bits = 8'b1100_0000;
      LSB  = 1'b0;
      for (int i = 7; i >= 1; i--) begin
         applyStimulus(bits[i], 1'b1, 1'b0);
      end
      checkOutput("t1_valid_before", {31'd0, out_valid}, 32'd0);
      applyStimulus(bits[0], 1'b1, 1'b0);
      checkOutput("t1_out", {24'd0, sipo_out}, 32'hC0);
      checkOutput("t1_valid", {31'd0, out_valid}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t1_valid_drop", {31'd0, out_valid}, 32'd0);
      checkOutput("t1_out_hold", {24'd0, sipo_out}, 32'hC0);

      // Test 2: LSB-first, same bit stream, enable alternating with idles.
      LSB = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(i < 2, 1'b1, 1'b0);
         if (i < 7) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            if (out_valid) pulses++;
         end
      end
      checkOutput("t2_no_early_valid", pulses, 0);
      checkOutput("t2_out", {24'd0, sipo_out}, 32'h03);
      checkOutput("t2_valid", {31'd0, out_valid}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t2_valid_drop", {31'd0, out_valid}, 32'd0);

      // Test 3: backpressure then overrun.
      out_ready = 1'b0;
      sendWord(8'h3C, 1'b0);
      checkOutput("t3_out_first", {24'd0, sipo_out}, 32'h3C);
      checkOutput("t3_overrun_first", {31'd0, overrun}, 32'd0);
      sendWord(8'h5A, 1'b0);
      checkOutput("t3_out_held", {24'd0, sipo_out}, 32'h3C);
      checkOutput("t3_valid_held", {31'd0, out_valid}, 32'd1);
      checkOutput("t3_overrun_set", {31'd0, overrun}, 32'd1);
      out_ready = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      out_ready = 1'b0;
      checkOutput("t3_valid_taken", {31'd0, out_valid}, 32'd0);
      checkOutput("t3_overrun_sticky", {31'd0, overrun}, 32'd1);
      overrun_clr = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      overrun_clr = 1'b0;
      checkOutput("t3_overrun_clr", {31'd0, overrun}, 32'd0);

      // Test 4: back-to-back handoff of 0x3C to 0x81 on the same edge.
      sendWord(8'h3C, 1'b0);
      checkOutput("t4_pending", {24'd0, sipo_out}, 32'h3C);
      word = 8'h81;
      LSB  = 1'b0;
      for (int i = 7; i >= 1; i--) begin
         applyStimulus(word[i], 1'b1, 1'b0);
      end
      out_ready = 1'b1;
      applyStimulus(word[0], 1'b1, 1'b0);
      checkOutput("t4_out_new", {24'd0, sipo_out}, 32'h81);
      checkOutput("t4_valid_stays", {31'd0, out_valid}, 32'd1);
      checkOutput("t4_no_overrun", {31'd0, overrun}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t4_valid_drop", {31'd0, out_valid}, 32'd0);

      // Test 5: three stray bits, then sync restarts the word as 0x81.
      pulses = 0;
      bits   = 8'b0000_0101;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(bits[i], 1'b1, 1'b0);
         if (out_valid) pulses++;
      end
      applyStimulus(1'b1, 1'b1, 1'b1);
      if (out_valid) pulses++;
      word = 8'h81;
      for (int i = 6; i >= 0; i--) begin
         applyStimulus(word[i], 1'b1, 1'b0);
         if (out_valid) pulses++;
      end
      checkOutput("t5_out", {24'd0, sipo_out}, 32'h81);
      checkOutput("t5_pulses", pulses, 1);

      // Test 7: LSB flips after the first bit; the word stays MSB-first.
      word = 8'h96;
      LSB  = 1'b0;
      applyStimulus(word[7], 1'b1, 1'b0);
      LSB = 1'b1;
      for (int i = 6; i >= 0; i--) begin
         applyStimulus(word[i], 1'b1, 1'b0);
      end
      checkOutput("t7_order_latched", {24'd0, sipo_out}, 32'h96);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Test 6: async reset after 5 bits of 0xFF, then a clean 0xA5.
      out_ready = 1'b0;
      LSB       = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0);
      end
      #2;
      resetn = 1'b0;
      #1;
      checkOutput("t6_reset_out", {24'd0, sipo_out}, 32'h00);
      checkOutput("t6_reset_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("t6_reset_overrun", {31'd0, overrun}, 32'd0);
      @(negedge clk);
      resetn    = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      sendWord(8'hA5, 1'b0);
      checkOutput("t6_out_after", {24'd0, sipo_out}, 32'hA5);
      checkOutput("t6_valid_after", {31'd0, out_valid}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always ends on its own.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: observed running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
